// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the 8-bit common-bus CPU: ALU ops, bus drivers,
// opcodes and instruction-register field positions.
package internal_defines;

   typedef enum logic [2:0] {
      A_PLUS_B  = 3'd0,
      A_MINUS_B = 3'd1,
      A_AND_B   = 3'd2,
      A_OR_B    = 3'd3,
      A_XOR_B   = 3'd4,
      NOT_A     = 3'd5,
      SHL_A     = 3'd6,
      SHR_A     = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      BUS_IMM = 2'd0,
      BUS_RF  = 2'd1,
      BUS_ALU = 2'd2,
      BUS_A   = 2'd3
   } bus_sel_t;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_ALU  = 3'd1,
      OP_LI   = 3'd2,
      OP_JMP  = 3'd3,
      OP_BZ   = 3'd4,
      OP_MOV  = 3'd5,
      OP_RSVD = 3'd6,
      OP_HALT = 3'd7
   } opcode_t;

   localparam int IR_W    = 14;
   localparam int OPC_MSB = 13;
   localparam int OPC_LSB = 11;
   localparam int RD_MSB  = 10;
   localparam int RD_LSB  = 8;
   localparam int RS_MSB  = 7;
   localparam int RS_LSB  = 5;
   localparam int ALU_MSB = 2;
   localparam int ALU_LSB = 0;

   // Register file is 8 entries deep; the address port is a full byte.
   function automatic logic [7:0] reg_addr(input logic [2:0] r);
      return {5'b0, r};
   endfunction

endpackage

// File: rtl/cpu_control_fsm_ir_decoder.sv
// Combinational field extraction from the 14-bit instruction register.
module ir_decoder
   import internal_defines::*;
(
   input  logic [IR_W-1:0] ir,
   output opcode_t         opcode,
   output logic [2:0]      rd,
   output logic [2:0]      rs,
   output alu_op_t         alu_op
);

   // IR[4:3] carry no control meaning; they only matter as part of imm8 in the datapath.
   logic unused_ir_bits;

   assign opcode         = opcode_t'(ir[OPC_MSB:OPC_LSB]);
   assign rd             = ir[RD_MSB:RD_LSB];
   assign rs             = ir[RS_MSB:RS_LSB];
   assign alu_op         = alu_op_t'(ir[ALU_MSB:ALU_LSB]);
   assign unused_ir_bits = ^ir[4:3];

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: fetch over a valid handshake, decode the IR,
// then step the bus/register-file enables one instruction at a time.
module cpu_control_fsm
   import internal_defines::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        imem_valid,
   input  logic [13:0] instruction_register,
   input  logic        rd_is_zero,
   output logic        imem_req,
   output logic        ir_load_en,
   output logic        pc_load_en,
   output logic        pc_sel,
   output logic [1:0]  bus_sel,
   output logic        a_load_en,
   output logic        b_load_en,
   output logic        rf_write_read,
   output logic [7:0]  rf_addr,
   output logic [2:0]  alu_op,
   output logic        instr_done,
   output logic        halted
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_RD_A, S_RD_B, S_ALU_WB, S_MV_RD,
      S_MV_WB, S_LI_WB, S_JMP, S_BZ_TEST, S_HALT
   } ctrl_state_t;

   ctrl_state_t state, state_next;
   opcode_t     opcode;
   logic [2:0]  rd, rs;
   alu_op_t     ir_alu_op;
   logic        fetch_accept;

   ir_decoder u_ir_decoder (
      .ir     (instruction_register),
      .opcode (opcode),
      .rd     (rd),
      .rs     (rs),
      .alu_op (ir_alu_op)
   );

   // NOTE: the state register uses non-blocking assignments so every flop samples
   // pre-edge values; the combinational block below uses blocking ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   // Masking with reset keeps a valid word from loading IR/PC while reset is held.
   assign fetch_accept = imem_valid && !reset;

   always_comb begin
      // NOTE: every output and next-state gets a default first, so no path can infer a latch.
      state_next    = state;
      imem_req      = 1'b0;
      ir_load_en    = 1'b0;
      pc_load_en    = 1'b0;
      pc_sel        = 1'b0;
      bus_sel       = BUS_IMM;
      a_load_en     = 1'b0;
      b_load_en     = 1'b0;
      rf_write_read = 1'b0;
      rf_addr       = 8'h00;
      alu_op        = A_PLUS_B;
      instr_done    = 1'b0;
      halted        = 1'b0;

      unique case (state)
         S_FETCH: begin
            imem_req = 1'b1;
            if (fetch_accept) begin
               ir_load_en = 1'b1;
               pc_load_en = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (opcode)
               OP_NOP, OP_RSVD: begin
                  instr_done = 1'b1;
                  state_next = S_FETCH;
               end
               OP_ALU:  state_next = S_RD_A;
               OP_LI:   state_next = S_LI_WB;
               OP_JMP:  state_next = S_JMP;
               OP_BZ:   state_next = S_BZ_TEST;
               OP_MOV:  state_next = S_MV_RD;
               OP_HALT: state_next = S_HALT;
            endcase
         end
         S_RD_A: begin
            rf_addr    = reg_addr(rd);
            bus_sel    = BUS_RF;
            a_load_en  = 1'b1;
            state_next = S_RD_B;
         end
         S_RD_B: begin
            rf_addr    = reg_addr(rs);
            bus_sel    = BUS_RF;
            b_load_en  = 1'b1;
            state_next = S_ALU_WB;
         end
         S_ALU_WB: begin
            alu_op        = ir_alu_op;
            bus_sel       = BUS_ALU;
            rf_write_read = 1'b1;
            rf_addr       = reg_addr(rd);
            instr_done    = 1'b1;
            state_next    = S_FETCH;
         end
         S_MV_RD: begin
            rf_addr    = reg_addr(rs);
            bus_sel    = BUS_RF;
            a_load_en  = 1'b1;
            state_next = S_MV_WB;
         end
         S_MV_WB: begin
            bus_sel       = BUS_A;
            rf_write_read = 1'b1;
            rf_addr       = reg_addr(rd);
            instr_done    = 1'b1;
            state_next    = S_FETCH;
         end
         S_LI_WB: begin
            rf_write_read = 1'b1;
            rf_addr       = reg_addr(rd);
            instr_done    = 1'b1;
            state_next    = S_FETCH;
         end
         S_JMP: begin
            pc_load_en = 1'b1;
            pc_sel     = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_BZ_TEST: begin
            rf_addr    = reg_addr(rd);
            pc_sel     = 1'b1;
            pc_load_en = rd_is_zero;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_next = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized self-checking bench for cpu_control_fsm against a per-instruction
// micro-step table model.
module tb_cpu_control_fsm;

   typedef struct packed {
      logic       imem_req;
      logic       ir_load;
      logic       pc_load;
      logic       pc_sel;
      logic [1:0] bus;
      logic       a_load;
      logic       b_load;
      logic       wr;
      logic [7:0] addr;
      logic [2:0] alu;
      logic       done;
      logic       halted;
   } outv_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_valid;
   logic [13:0] instruction_register;
   logic        rd_is_zero;
   logic        imem_req, ir_load_en, pc_load_en, pc_sel;
   logic [1:0]  bus_sel;
   logic        a_load_en, b_load_en, rf_write_read;
   logic [7:0]  rf_addr;
   logic [2:0]  alu_op;
   logic        instr_done, halted;

   outv_t obs;
   int    vectors     = 0;
   int    miscompares = 0;
   outv_t exp_q[$];
   logic  vld_q[$];

   cpu_control_fsm dut (
      .clock                (clock),
      .reset                (reset),
      .imem_valid           (imem_valid),
      .instruction_register (instruction_register),
      .rd_is_zero           (rd_is_zero),
      .imem_req             (imem_req),
      .ir_load_en           (ir_load_en),
      .pc_load_en           (pc_load_en),
      .pc_sel               (pc_sel),
      .bus_sel              (bus_sel),
      .a_load_en            (a_load_en),
      .b_load_en            (b_load_en),
      .rf_write_read        (rf_write_read),
      .rf_addr              (rf_addr),
      .alu_op               (alu_op),
      .instr_done           (instr_done),
      .halted               (halted)
   );

   always #5 clock = ~clock;

   assign obs = {imem_req, ir_load_en, pc_load_en, pc_sel, bus_sel, a_load_en, b_load_en,
                 rf_write_read, rf_addr, alu_op, instr_done, halted};

   function automatic outv_t fetch_v(input logic accept);
      outv_t v = '0;
      v.imem_req = 1'b1;
      v.ir_load  = accept;
      v.pc_load  = accept;
      return v;
   endfunction

   // Cycles outside FETCH get a random imem_valid, which the design must ignore.
   function automatic void push(input outv_t v);
      exp_q.push_back(v);
      vld_q.push_back(1'($urandom_range(0, 1)));
   endfunction

   // Expected per-cycle outputs for one instruction, from the instruction's micro-steps.
   function automatic void model_instr(input logic [13:0] ir, input int waits, input logic z);
      outv_t      v;
      logic [2:0] op = ir[13:11];
      logic [7:0] rd = {5'b0, ir[10:8]};
      logic [7:0] rs = {5'b0, ir[7:5]};
      for (int i = 0; i < waits; i++) begin
         exp_q.push_back(fetch_v(1'b0));
         vld_q.push_back(1'b0);
      end
      exp_q.push_back(fetch_v(1'b1));
      vld_q.push_back(1'b1);
      v = '0;
      v.done = (op == 3'd0 || op == 3'd6);
      push(v);
      case (op)
         3'd1: begin
            v = '0; v.addr = rd; v.bus = 2'd1; v.a_load = 1'b1; push(v);
            v = '0; v.addr = rs; v.bus = 2'd1; v.b_load = 1'b1; push(v);
            v = '0; v.alu = ir[2:0]; v.bus = 2'd2; v.wr = 1'b1; v.addr = rd; v.done = 1'b1; push(v);
         end
         3'd2: begin v = '0; v.wr = 1'b1; v.addr = rd; v.done = 1'b1; push(v); end
         3'd3: begin v = '0; v.pc_load = 1'b1; v.pc_sel = 1'b1; v.done = 1'b1; push(v); end
         3'd4: begin
            v = '0; v.addr = rd; v.pc_sel = 1'b1; v.pc_load = z; v.done = 1'b1; push(v);
         end
         3'd5: begin
            v = '0; v.addr = rs; v.bus = 2'd1; v.a_load = 1'b1; push(v);
            v = '0; v.bus = 2'd3; v.wr = 1'b1; v.addr = rd; v.done = 1'b1; push(v);
         end
         3'd7: for (int i = 0; i < 12; i++) begin v = '0; v.halted = 1'b1; push(v); end
         default: ;
      endcase
   endfunction

   task automatic step(input logic vld, input logic [13:0] ir, input logic z);
      @(posedge clock);
      #1;
      imem_valid           = vld;
      instruction_register = ir;
      rd_is_zero           = z;
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1; imem_valid = 1'b0; instruction_register = '0; rd_is_zero = 1'b0;
      #12;
      @(negedge clock);
      vectors++;
      if (obs !== fetch_v(1'b0)) begin
         miscompares++;
         $display("FAIL reset_state: got %h want %h", obs, fetch_v(1'b0));
      end
      reset = 1'b0;
   endtask

   task automatic test_li();
      logic [13:0] ir = 14'b010_011_00101010;
      outv_t e;
      logic  v;
      model_instr(ir, 0, 1'b0);
      for (int c = 1; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); v = vld_q.pop_front();
         step(v, ir, 1'b0);
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL li cyc%0d: got %h want %h", c, obs, e);
         end
      end
   endtask

   task automatic test_alu();
      logic [13:0] ir = {3'd1, 3'd1, 3'd2, 2'b00, 3'd1};
      outv_t e;
      logic  v;
      int    done_cyc = 0;
      model_instr(ir, 0, 1'b0);
      for (int c = 1; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); v = vld_q.pop_front();
         step(v, ir, 1'b0);
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL alu_sub cyc%0d: got %h want %h", c, obs, e);
         end
         if (instr_done === 1'b1 && done_cyc == 0) done_cyc = c;
      end
      vectors++;
      if (done_cyc !== 5) begin
         miscompares++;
         $display("FAIL alu_latency: got %0d want 5", done_cyc);
      end
   endtask

   task automatic test_bz();
      logic [13:0] ir = {3'd4, 3'd4, 8'h10};
      outv_t e;
      logic  v;
      for (int k = 0; k < 2; k++) begin
         logic z = (k == 0);
         model_instr(ir, 0, z);
         for (int c = 1; exp_q.size() > 0; c++) begin
            e = exp_q.pop_front(); v = vld_q.pop_front();
            step(v, ir, z);
            vectors++;
            if (obs !== e) begin
               miscompares++;
               $display("FAIL bz_z%0d cyc%0d: got %h want %h", z, c, obs, e);
            end
         end
      end
   endtask

   task automatic test_fetch_wait();
      logic [13:0] ir = {3'd2, 3'd5, 8'hA5};
      outv_t e;
      logic  v;
      int    ir_loads = 0, pc_loads = 0, ir_cyc = 0;
      model_instr(ir, 3, 1'b0);
      for (int c = 1; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); v = vld_q.pop_front();
         step(v, ir, 1'b0);
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL fetch_wait cyc%0d: got %h want %h", c, obs, e);
         end
         if (ir_load_en === 1'b1) begin ir_loads++; ir_cyc = c; end
         if (pc_load_en === 1'b1) pc_loads++;
      end
      vectors++;
      if (ir_loads !== 1 || ir_cyc !== 4 || pc_loads !== 1) begin
         miscompares++;
         $display("FAIL fetch_wait_loads: got ir=%0d@%0d pc=%0d want ir=1@4 pc=1",
                  ir_loads, ir_cyc, pc_loads);
      end
   endtask

   task automatic test_random();
      outv_t e;
      logic  v;
      for (int n = 0; n < 40; n++) begin
         logic [13:0] ir = 14'($urandom);
         logic        z  = 1'($urandom_range(0, 1));
         int          w  = $urandom_range(0, 2);
         ir[13:11] = 3'($urandom_range(0, 6));
         model_instr(ir, w, z);
         for (int c = 1; exp_q.size() > 0; c++) begin
            e = exp_q.pop_front(); v = vld_q.pop_front();
            step(v, ir, z);
            vectors++;
            if (obs !== e) begin
               miscompares++;
               $display("FAIL random n%0d ir=%h cyc%0d: got %h want %h", n, ir, c, obs, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] ir = {3'd1, 3'd6, 3'd3, 2'b00, 3'd2};
      outv_t e;
      logic  v;
      model_instr(ir, 0, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         e = exp_q.pop_front(); v = vld_q.pop_front();
         step(v, ir, 1'b0);
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_mid_pre cyc%0d: got %h want %h", c, obs, e);
         end
      end
      exp_q.delete();
      vld_q.delete();
      reset = 1'b1;
      imem_valid = 1'b1;
      #1;
      vectors++;
      if (obs !== fetch_v(1'b0)) begin
         miscompares++;
         $display("FAIL reset_mid_assert: got %h want %h", obs, fetch_v(1'b0));
      end
      @(negedge clock);
      vectors++;
      if (obs !== fetch_v(1'b0)) begin
         miscompares++;
         $display("FAIL reset_mid_held: got %h want %h", obs, fetch_v(1'b0));
      end
      imem_valid = 1'b0;
      reset = 1'b0;
      #1;
      vectors++;
      if (obs !== fetch_v(1'b0)) begin
         miscompares++;
         $display("FAIL reset_mid_release: got %h want %h", obs, fetch_v(1'b0));
      end
   endtask

   task automatic test_halt();
      logic [13:0] ir = {3'd7, 11'h2A5};
      outv_t e;
      logic  v;
      model_instr(ir, 1, 1'b0);
      for (int c = 1; exp_q.size() > 0; c++) begin
         e = exp_q.pop_front(); v = vld_q.pop_front();
         step(v, ir, 1'b0);
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL halt cyc%0d: got %h want %h", c, obs, e);
         end
      end
      imem_valid = 1'b0;
      reset = 1'b1;
      #1;
      vectors++;
      if (obs !== fetch_v(1'b0)) begin
         miscompares++;
         $display("FAIL halt_reset: got %h want %h", obs, fetch_v(1'b0));
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_li();
      test_alu();
      test_bz();
      test_fetch_wait();
      test_random();
      test_reset_mid();
      test_li();
      test_halt();
      test_alu();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control sequencer for the 8-bit common-bus CPU. Each cycle it chooses one source to drive the shared 8-bit bus and asserts the load/write enables for the program counter, instruction register, ALU operand registers A/B and the single-port register file. It fetches over a valid-qualified instruction-memory handshake, decodes the 14-bit instruction register and sequences one instruction at a time.

## Interface
- No parameters.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_valid`  in  1  instruction word on the memory port is valid this cycle.
- `instruction_register`  in  14  current IR contents.
- `rd_is_zero`  in  1  register-file `r_data == 0` (datapath compare).
- `imem_req`  out  1  fetch request.
- `ir_load_en`  out  1  load IR from the memory port.
- `pc_load_en`  out  1  load PC.
- `pc_sel`  out  1  0 = PC+1, 1 = bus.
- `bus_sel`  out  2  bus driver: `BUS_IMM`=0, `BUS_RF`=1, `BUS_ALU`=2, `BUS_A`=3.
- `a_load_en`, `b_load_en`  out  1 each  load operand register A/B from bus.
- `rf_write_read`  out  1  1 = write `rf_addr` from bus, 0 = read.
- `rf_addr`  out  8  register-file address; upper 5 bits always 0.
- `alu_op`  out  3  `alu_op_t` driven to the ALU.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `halted`  out  1  HALT has executed.

## Operation
- IR fields: `[13:11]` opcode, `[10:8]` rd, `[7:5]` rs, `[2:0]` alu_op, `[7:0]` imm8.
- Opcodes: 0 NOP, 1 ALU (rd ← rd op rs), 2 LI (rd ← imm8), 3 JMP (PC ← imm8), 4 BZ (if rd==0, PC ← imm8), 5 MOV (rd ← rs), 6 reserved (executes as NOP), 7 HALT.
- FETCH: `imem_req`=1. In the cycle `imem_valid`=1: `ir_load_en`=1 and `pc_load_en`=1 with `pc_sel`=0, then → DECODE. Otherwise hold.
- DECODE:
  - NOP/reserved: `instr_done`, → FETCH.
  - ALU → RD_A. MOV → MV_RD. LI → LI_WB. JMP → JMP. BZ → BZ_TEST. HALT → HALT.
- RD_A: `rf_addr`=rd, `bus_sel`=RF, `a_load_en`. → RD_B.
- RD_B: `rf_addr`=rs, `bus_sel`=RF, `b_load_en`. → ALU_WB.
- ALU_WB: `alu_op`=IR[2:0], `bus_sel`=ALU, `rf_write_read`=1, `rf_addr`=rd, `instr_done`. → FETCH.
- MV_RD: `rf_addr`=rs, `bus_sel`=RF, `a_load_en`. → MV_WB.
- MV_WB: `bus_sel`=A, write rd, `instr_done`. → FETCH.
- LI_WB: `bus_sel`=IMM, write rd, `instr_done`. → FETCH.
- JMP: `bus_sel`=IMM, `pc_load_en`, `pc_sel`=1, `instr_done`. → FETCH.
- BZ_TEST: `rf_addr`=rd, `bus_sel`=IMM, `pc_sel`=1, `pc_load_en`=`rd_is_zero`, `instr_done`. → FETCH.
- HALT: `halted`=1, all enables 0, `imem_req`=0. Exits only via reset.
- Defaults in every state unless listed above: all enables 0, `bus_sel`=IMM, `pc_sel`=0, `rf_addr`=0, `alu_op`=A_PLUS_B.

## Timing
- Reset: state=FETCH. All outputs 0 except `imem_req`=1 (FETCH default) and `halted`=0. Reset mid-instruction aborts it; no partial write or PC load occurs after assertion.
- Outputs are Moore, except `ir_load_en`/`pc_load_en` in FETCH, which are gated combinationally by `imem_valid`.
- Latency with `imem_valid` held high: NOP 2 cycles, LI/JMP/BZ 3, MOV 4, ALU 5. Each wait cycle in FETCH adds 1.
- `imem_valid` while not in FETCH is ignored.
- Exactly one `instr_done` pulse per retired instruction; none for HALT.

## Structure
- Shared package `internal_defines`: `alu_op_t`, `bus_sel_t`, opcode enum `opcode_t`, IR field bit positions.
- State enum `ctrl_state_t` is local to the module.
- Single module. The optional sub-module `ir_decoder` (IR → opcode/rd/rs/alu_op/imm8, combinational) holds the field extraction.

## Test plan
- Reset mid-ALU_WB (assert in RD_B cycle) → no `rf_write_read`; after release, FETCH with `imem_req`=1.
- IR=`0b010_011_00101010` (LI r3,42), `imem_valid` high → cycle 3 has `bus_sel`=IMM, `rf_addr`=3, `rf_write_read`=1, `instr_done`=1.
- ALU r1 ← r1 − r2 (alu_op=A_MINUS_B) → RD_A addr 1, RD_B addr 2, ALU_WB `alu_op`=1 and write addr 1; 5 cycles total.
- BZ r4 →0x10 with `rd_is_zero`=1 → `pc_load_en`=1, `pc_sel`=1; repeat with 0 → `pc_load_en`=0, `instr_done`=1 both times.
- FETCH with `imem_valid` low for 3 cycles, then high → `ir_load_en` only in the 4th cycle; PC loaded once.
- HALT → `halted`=1 and `imem_req`=0 for 10+ cycles, no further `instr_done`; reset clears `halted`.
